// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the CDC IN-side byte-stream arbiter and reusable round-robin helpers.
package cdc_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned MaxCh = 16;

  // First set request strictly after `last`, wrapping modulo n_ch; 0 when nothing is set.
  function automatic int unsigned rr_pick(input logic [MaxCh-1:0] req,
                                          input int unsigned last,
                                          input int unsigned n_ch);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxCh; i++) begin
      if (i <= n_ch && !found) begin
        idx = (last + i) % n_ch;
        if (req[idx[3:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority.sv
// Combinational round-robin picker: next requester after `last_i`, wrapping around N_CH.
module rr_priority
  import cdc_arb_pkg::*;
#(
  parameter  int unsigned N_CH = 7,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] last_i,
  output logic [CH_W-1:0] grant_o,
  output logic            any_o
);

  always_comb begin
    grant_o = CH_W'(rr_pick(MaxCh'(req_i), 32'(last_i), N_CH));
    any_o   = |req_i;
  end

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin burst scheduler sharing one registered byte sink among N_CH channel sources;
// each output byte carries its source channel tag.
module cdc_in_arbiter
  import cdc_arb_pkg::*;
#(
  parameter  int unsigned N_CH      = 7,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned CH_W      = $clog2(N_CH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [8*N_CH-1:0] in_data_i,
  input  logic [N_CH-1:0]   in_valid_i,
  output logic [N_CH-1:0]   in_ready_o,
  output logic [7:0]        out_data_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CH_W-1:0]  pick;
  logic             any_req;

  logic [7:0]       out_data_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_valid_q;

  logic             grant_valid;
  logic [7:0]       grant_data;
  logic             can_load;
  logic             load;
  logic             burst_end;

  rr_priority #(
    .N_CH (N_CH)
  ) u_rr_priority (
    .req_i   (in_valid_i),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (any_req)
  );

  assign grant_valid = in_valid_i[grant_q];
  assign grant_data  = in_data_i[{grant_q, 3'b000} +: 8];
  assign can_load    = ~out_valid_q | out_ready_i;
  // Gated by reset so no handshake is reported in a cycle whose state is being discarded.
  assign load        = rstn_i & (state_q == ST_GRANT) & grant_valid & can_load;
  // A valid drop only ends the burst when the register could have taken a byte.
  assign burst_end   = (state_q == ST_GRANT) &
                       ((load & (count_q == CNT_W'(MAX_BURST - 1))) | (~grant_valid & can_load));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= CH_W'(N_CH - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          grant_d = pick;
          last_d  = pick;
          count_d = '0;
        end
      end
      ST_GRANT: begin
        if (load) count_d = count_q + CNT_W'(1);
        if (burst_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o          = '0;
    in_ready_o[grant_q] = load;
    busy_o              = (state_q == ST_GRANT);
  end

  // Output register drains on out_ready_i regardless of arbiter state.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_data_q  <= grant_data;
      out_ch_q    <= grant_q;
      out_valid_q <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Directed self-checking bench for cdc_in_arbiter with modelled per-channel byte sources.
module tb_cdc_in_arbiter;

  localparam int N  = 7;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [8*N-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [7:0]     out_data;
  logic [CW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;

  int             ptr [N];
  int             lim [N];
  logic [7:0]     base [N];
  logic [N-1:0]   last_rdy;
  logic [CW-1:0]  qc [$];
  logic [7:0]     qd [$];
  int             tests = 0;
  int             fails = 0;

  always #5 clk = ~clk;

  cdc_in_arbiter #(
    .N_CH      (N),
    .MAX_BURST (8)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd_src();
    for (int k = 0; k < N; k++) begin
      in_valid[k]        = (ptr[k] < lim[k]);
      in_data[8*k +: 8]  = base[k] + 8'(ptr[k]);
    end
  endtask

  task automatic clr_src();
    for (int k = 0; k < N; k++) begin
      ptr[k]  = 0;
      lim[k]  = 0;
      base[k] = 8'(k << 4);
    end
    upd_src();
  endtask

  // Sample handshakes at the falling edge, advance sources after the rising edge.
  task automatic tick();
    @(negedge clk);
    last_rdy = in_ready;
    if (out_valid && out_ready) begin
      qc.push_back(out_ch);
      qd.push_back(out_data);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (last_rdy[k]) ptr[k]++;
    upd_src();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    qc.delete();
    qd.delete();
  endtask

  initial begin
    logic [10:0] e4 [10];
    logic [7:0]  pd;
    logic [CW-1:0] pc;
    logic        stalled;
    int          e;
    int          nst;

    // 1: reset and idle
    clr_src();
    rstn = 1'b0;
    repeat (4) begin
      tick();
      chk("t1_reset_outs", {out_valid, out_ch, out_data, in_ready, busy}, 32'd0);
    end
    rstn = 1'b1;
    repeat (10) begin
      tick();
      chk("t1_idle_outs", {out_valid, out_ch, out_data, in_ready, busy}, 32'd0);
    end

    // 2: single channel 3, 20 bytes -> bursts 8, 8, 4
    lim[3] = 20;
    upd_src();
    tick();
    chk("t2_arb_latency", out_valid, 1'b0);
    chk("t2_busy", busy, 1'b1);
    for (int c = 2; c <= 25; c++) begin
      tick();
      e = c - 2;
      if (e <= 7)       e = e;
      else if (e == 8)  e = -1;
      else if (e <= 16) e = e - 1;
      else if (e == 17) e = -1;
      else if (e <= 21) e = e - 2;
      else              e = -1;
      if (e < 0) chk("t2_gap_valid", out_valid, 1'b0);
      else chk("t2_byte", {out_valid, out_ch, out_data}, {1'b1, 3'd3, 8'h30 + 8'(e)});
    end

    // 3: all channels continuously valid
    clr_src();
    do_reset();
    for (int k = 0; k < N; k++) lim[k] = 64;
    upd_src();
    repeat (80) tick();
    chk("t3_count", 32'(qc.size() >= 64), 32'd1);
    for (int i = 0; i < 64; i++) begin
      int b;
      int ch;
      b  = i / 8;
      ch = b % 7;
      if (i < qc.size())
        chk("t3_stream", {qc[i], qd[i]}, {3'(ch), 8'(ch << 4) + 8'((b / 7) * 8 + i % 8)});
    end
    for (int k = 0; k < N; k++) lim[k] = 0;
    upd_src();
    repeat (3) tick();

    // 4: channel 1 drops after 3 bytes while channel 5 waits
    clr_src();
    do_reset();
    lim[1] = 3;
    upd_src();
    tick();
    lim[5] = 4;
    upd_src();
    repeat (4) tick();
    lim[1] = 6;
    upd_src();
    repeat (20) tick();
    e4 = '{{3'd1, 8'h10}, {3'd1, 8'h11}, {3'd1, 8'h12},
           {3'd5, 8'h50}, {3'd5, 8'h51}, {3'd5, 8'h52}, {3'd5, 8'h53},
           {3'd1, 8'h13}, {3'd1, 8'h14}, {3'd1, 8'h15}};
    chk("t4_count", qc.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < qc.size()) chk("t4_stream", {qc[i], qd[i]}, e4[i]);

    // 5: back-pressure on channel 2
    clr_src();
    do_reset();
    lim[2] = 8;
    upd_src();
    nst = 0;
    for (int i = 0; i < 48; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      stalled   = out_valid && !out_ready;
      pd        = out_data;
      pc        = out_ch;
      tick();
      if (stalled) begin
        nst++;
        chk("t5_hold", {out_ch, out_data}, {pc, pd});
        chk("t5_ready_low", last_rdy[2], 1'b0);
      end
    end
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t5_stall_seen", 32'(nst > 0), 32'd1);
    chk("t5_count", qc.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < qc.size()) chk("t5_stream", {qc[i], qd[i]}, {3'd2, 8'h20 + 8'(i)});

    // 6: reset mid-burst on channel 4
    clr_src();
    do_reset();
    lim[4] = 20;
    upd_src();
    repeat (6) tick();
    chk("t6_pre_reset", {out_valid, out_ch, out_data}, {1'b1, 3'd4, 8'h44});
    rstn   = 1'b0;
    lim[0] = 5;
    upd_src();
    tick();
    chk("t6_rst_ready", last_rdy, 7'd0);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    rstn = 1'b1;
    tick();
    chk("t6_regrant_busy", busy, 1'b1);
    tick();
    chk("t6_ch0_first", {out_valid, out_ch, out_data}, {1'b1, 3'd0, 8'h00});
    chk("t6_ch4_ptr", ptr[4], 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
